// File: rtl/gbf_flgact_reader.sv
// -----------------------------------------------------------------------------
// gbf_flgact_reader
//   Read-side controller for the global-buffer flag-activation RAM. Accepts a
//   burst command (base address, word count), issues one-cycle-latency reads on
//   the RAM read port and streams the words out over valid/ready. A 2-entry
//   FIFO absorbs the RAM latency; reads are gated by a credit check so that
//   words already in the FIFO plus the word in flight never exceed 2. Reads
//   yield to the writer whenever wr_conflict is high (shared address bus).
//
// Ports
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : command pulse, taken only when busy=0
//   base_addr, len : burst start address and word count (0..2^SRAM_DEPTH_BIT)
//   busy, done     : burst in progress / one-cycle completion pulse
//   wr_conflict    : writer owns the RAM port this cycle
//   ram_read_en    : RAM read strobe
//   ram_addr_r     : RAM read address (holds last issued address when idle)
//   ram_data_out   : RAM read data, valid the cycle after ram_read_en
//   out_valid, out_ready, out_data, out_last : output stream (FIFO head)
// -----------------------------------------------------------------------------
module gbf_flgact_reader #(
    parameter int SRAM_DEPTH_BIT = 6,
    parameter int SRAM_WIDTH     = 28
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [SRAM_DEPTH_BIT-1:0] base_addr,
    input  logic [SRAM_DEPTH_BIT:0]   len,
    output logic                      busy,
    output logic                      done,
    input  logic                      wr_conflict,
    output logic                      ram_read_en,
    output logic [SRAM_DEPTH_BIT-1:0] ram_addr_r,
    input  logic [SRAM_WIDTH-1:0]     ram_data_out,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SRAM_WIDTH-1:0]     out_data,
    output logic                      out_last
);

    localparam int AW = SRAM_DEPTH_BIT;
    localparam int CW = SRAM_DEPTH_BIT + 1;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   ptr;
    logic [AW-1:0]   last_addr;
    logic [CW-1:0]   issue_left;
    logic [CW-1:0]   pop_left;
    logic            inflight;
    logic [1:0]      fifo_count;
    logic            wr_idx, rd_idx;
    logic [SRAM_WIDTH-1:0] fifo_mem [2];

    logic            accept;
    logic            issue;
    logic            pop;
    logic            push;
    logic [2:0]      credit;
    logic [2:0]      credit_limit;

    assign accept = (state == IDLE) && start;
    assign pop    = out_valid && out_ready;
    assign push   = inflight;

    // A pop in this cycle frees a slot, so it raises the limit rather than
    // lowering the occupancy: (count + inflight - pop) < 2.
    assign credit       = {1'b0, fifo_count} + {2'b00, inflight};
    assign credit_limit = 3'd2 + {2'b00, pop};

    assign issue = (state == READ) && (issue_left != '0) && !wr_conflict
                   && (credit < credit_limit);

    assign ram_read_en = issue;
    assign ram_addr_r  = issue ? ptr : last_addr;

    assign busy      = (state != IDLE);
    assign out_valid = (fifo_count != 2'd0);
    assign out_data  = fifo_mem[rd_idx];
    assign out_last  = out_valid && (pop_left == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: next state defaults to the current state before any branch so
        // that no path leaves state_nxt unassigned (which would infer a latch).
        state_nxt = state;
        unique case (state)
            IDLE:  if (start && (len != '0))                  state_nxt = READ;
            READ:  if (issue && (issue_left == CW'(1)))       state_nxt = DRAIN;
            DRAIN: if (pop && (pop_left == CW'(1)))           state_nxt = IDLE;
            default:                                          state_nxt = IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            last_addr  <= '0;
            issue_left <= '0;
            pop_left   <= '0;
            inflight   <= 1'b0;
            done       <= 1'b0;
        end else begin
            inflight <= issue;
            done     <= (accept && (len == '0)) || (pop && (pop_left == CW'(1)));
            if (accept && (len != '0)) begin
                ptr        <= base_addr;
                issue_left <= len;
                pop_left   <= len;
            end else begin
                if (issue) begin
                    ptr        <= ptr + AW'(1);
                    last_addr  <= ptr;
                    issue_left <= issue_left - CW'(1);
                end
                if (pop) begin
                    pop_left <= pop_left - CW'(1);
                end
            end
        end
    end

    // Two-entry FIFO. The word read in the previous cycle is captured exactly
    // once, in the cycle after the issue; hold cycles never write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the storage is only two words and out_data must read zero
            // out of reset, so it is cleared along with the pointers.
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_idx      <= 1'b0;
            rd_idx      <= 1'b0;
            fifo_count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_idx] <= ram_data_out;
                wr_idx           <= ~wr_idx;
            end
            if (pop) begin
                rd_idx <= ~rd_idx;
            end
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_gbf_flgact_reader.sv
// -----------------------------------------------------------------------------
// tb_gbf_flgact_reader
//   Directed bench for gbf_flgact_reader with a behavioural RAM, a queue-based
//   reference model of the burst/credit rules, a per-cycle compare process and
//   hand-computed cycle/address expectations for the key scenarios.
// -----------------------------------------------------------------------------
module tb_gbf_flgact_reader;

    localparam int AW = 6;
    localparam int DW = 28;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic          wr_conflict;
    logic          ram_read_en;
    logic [AW-1:0] ram_addr_r;
    logic [DW-1:0] ram_data_out;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;

    gbf_flgact_reader #(.SRAM_DEPTH_BIT(AW), .SRAM_WIDTH(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .base_addr    (base_addr),
        .len          (len),
        .busy         (busy),
        .done         (done),
        .wr_conflict  (wr_conflict),
        .ram_read_en  (ram_read_en),
        .ram_addr_r   (ram_addr_r),
        .ram_data_out (ram_data_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural RAM (1-cycle read latency) -----------------
    function automatic logic [DW-1:0] ram_word(input int a);
        return DW'(32'h00A5_0000 + a * 32'h0001_0203);
    endfunction

    logic [DW-1:0] ram_mem [64];
    initial begin
        for (int i = 0; i < 64; i++) ram_mem[i] = ram_word(i);
        ram_data_out = '0;
    end
    always @(posedge clk) if (ram_read_en) ram_data_out <= ram_mem[ram_addr_r];

    // ---------------- reference model ---------------------------------------
    // Every read issued but not yet consumed is an item in mq. A word becomes
    // visible two cycles after its read, and at most 2 items may be owed.
    typedef struct {
        logic [DW-1:0] data;
        bit            last;
        int            avail;
    } item_t;

    item_t mq[$];
    int    gcyc = 0;
    bit    m_active;
    int    m_rd_left;
    int    m_rd_addr;
    bit    m_done;

    always @(posedge clk) gcyc <= gcyc + 1;

    function automatic bit m_valid();
        return (mq.size() > 0) && (mq[0].avail <= gcyc);
    endfunction

    function automatic bit m_pop();
        return m_valid() && out_ready;
    endfunction

    function automatic bit m_issue();
        return (m_rd_left > 0) && !wr_conflict && ((mq.size() - int'(m_pop())) < 2);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_active  <= 1'b0;
            m_rd_left <= 0;
            m_rd_addr <= 0;
            m_done    <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_issue()) begin
                mq.push_back('{data: ram_word(m_rd_addr), last: (m_rd_left == 1), avail: gcyc + 2});
                m_rd_addr <= (m_rd_addr + 1) % 64;
                m_rd_left <= m_rd_left - 1;
            end
            if (m_pop()) begin
                if (mq[0].last) begin
                    m_active <= 1'b0;
                    m_done   <= 1'b1;
                end
                void'(mq.pop_front());
            end
            if (!m_active && start) begin
                if (len == 0) begin
                    m_done <= 1'b1;
                end else begin
                    m_active  <= 1'b1;
                    m_rd_left <= int'(len);
                    m_rd_addr <= int'(base_addr);
                end
            end
        end
    end

    // ---------------- per-cycle compare --------------------------------------
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", busy, m_active);
            check("done", done, m_done);
            check("ram_read_en", ram_read_en, m_issue());
            if (m_issue()) check("ram_addr_r", ram_addr_r, m_rd_addr);
            check("out_valid", out_valid, m_valid());
            if (m_valid()) begin
                check("out_data", out_data, mq[0].data);
                check("out_last", out_last, mq[0].last);
            end
        end
    end

    // ---------------- cycle recorder (relative to start cycle t0) ------------
    int t0 = 0;
    int rec_addr [80];
    int rec_done;
    int rec_last;

    always @(negedge clk) begin
        automatic int rel = gcyc - t0;
        if (rel == 0) begin
            for (int i = 0; i < 80; i++) rec_addr[i] = -1;
            rec_done = -1;
            rec_last = -1;
        end
        if (rst_n && rel >= 0 && rel < 80) begin
            if (ram_read_en) rec_addr[rel] = int'(ram_addr_r);
            if (done && rec_done < 0) rec_done = rel;
            if (out_last) rec_last = rel;
        end
    end

    // ---------------- stimulus -----------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_start(input int b, input int l);
        base_addr = AW'(b);
        len       = (AW + 1)'(l);
        start     = 1'b1;
        t0        = gcyc;
        step();
        start     = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((m_active || busy) && n < 300) begin
            step();
            n++;
        end
        check({name, "_timeout"}, (n < 300), 1'b1);
        step();
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  busy, 1'b0);
        check({tag, "_done"},  done, 1'b0);
        check({tag, "_rden"},  ram_read_en, 1'b0);
        check({tag, "_addr"},  ram_addr_r, '0);
        check({tag, "_valid"}, out_valid, 1'b0);
        check({tag, "_last"},  out_last, 1'b0);
        check({tag, "_data"},  out_data, '0);
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        base_addr   = '0;
        len         = '0;
        wr_conflict = 1'b0;
        out_ready   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        step();

        // base=5 len=4 unstalled: reads in cycles 1..4, last in 6, done in 7
        run_start(5, 4);
        wait_idle("b5");
        for (int c = 1; c <= 4; c++) check("b5_rd_addr", rec_addr[c], 4 + c);
        check("b5_no_5th_read", rec_addr[5], -1);
        check("b5_last_cyc", rec_last, 6);
        check("b5_done_cyc", rec_done, 7);

        // address wrap: 62,63,0,1
        run_start(62, 4);
        wait_idle("wrap");
        check("wrap_c2", rec_addr[2], 63);
        check("wrap_c3", rec_addr[3], 0);
        check("wrap_c4", rec_addr[4], 1);

        // backpressure: out_ready pattern 1,0,0,1 repeating
        run_start(10, 8);
        for (int k = 0; k < 200 && (m_active || busy); k++) begin
            out_ready = (k % 4 == 0) || (k % 4 == 3);
            step();
        end
        out_ready = 1'b1;
        wait_idle("bp");

        // writer conflict in cycles 2-3: done moves from 9 to 11
        run_start(20, 6);
        wr_conflict = 1'b0;
        step();
        wr_conflict = 1'b1;
        step();
        step();
        wr_conflict = 1'b0;
        wait_idle("wc");
        check("wc_c1", rec_addr[1], 20);
        check("wc_c2", rec_addr[2], -1);
        check("wc_c3", rec_addr[3], -1);
        check("wc_c4", rec_addr[4], 21);
        check("wc_done_cyc", rec_done, 11);

        // len=0: done in cycle 1, no reads
        run_start(7, 0);
        step();
        step();
        check("len0_done_cyc", rec_done, 1);
        check("len0_no_read", rec_addr[1], -1);

        // start while busy is ignored
        run_start(30, 4);
        base_addr = 6'd0;
        len       = 7'd2;
        start     = 1'b1;
        step();
        start     = 1'b0;
        wait_idle("ign");
        check("ign_c1", rec_addr[1], 30);
        check("ign_c4", rec_addr[4], 33);
        check("ign_done_cyc", rec_done, 7);

        // full depth
        run_start(0, 64);
        wait_idle("full");
        check("full_c64", rec_addr[64], 63);
        check("full_done_cyc", rec_done, 67);

        // reset mid-burst after 3 words, then a clean burst
        run_start(40, 8);
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        step();
        rst_n = 1'b1;
        step();
        run_start(50, 3);
        wait_idle("post");
        check("post_c1", rec_addr[1], 50);
        check("post_done_cyc", rec_done, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
